dr_memreq_sched: RTL and testbench
==================================

Name: dr_memreq_sched

Overview:
- Directory-bank scheduler that owns the single drtomem_req channel.
- Arbitrates between L2 demand requests and L2 prefetch requests.
- Allocates DRIDs from a bounded pool and frees them on memtodr_ack.
- Holds prefetches in a small drop-oldest queue; a prefetch is cancelled when a demand to the same 64B line arrives.

Parameters:
- PADDR_W, 50, physical address width
- CMD_W, 3, request command width
- DRID_W, 6, DRID field width
- NUM_DRID, 16, DRIDs in pool (max outstanding memory requests), 1..2^DRID_W
- PF_DEPTH, 8, prefetch queue entries (4, 8 or 16; power of two)
- PF_CMD, 3'd0, cmd driven on drtomem_req for prefetch grants
- STARVE_MAX, 4, consecutive demand grants allowed while a prefetch waits

Ports:
- clk  in  1  clock; all state on posedge
- reset  in  1  synchronous, active-high
- dem_valid  in  1  demand request valid
- dem_retry  out  1  demand backpressure
- dem_paddr  in  PADDR_W  demand address
- dem_cmd  in  CMD_W  demand command
- pf_valid  in  1  prefetch valid
- pf_retry  out  1  tied 0; prefetches are never backpressured
- pf_paddr  in  PADDR_W  prefetch address
- drtomem_req_valid  out  1  memory request valid (registered)
- drtomem_req_retry  in  1  memory backpressure
- drtomem_req_paddr  out  PADDR_W  request address
- drtomem_req_cmd  out  CMD_W  request command
- drtomem_req_drid  out  DRID_W  allocated DRID
- memtodr_ack_valid  in  1  memory ack
- memtodr_ack_drid  in  DRID_W  DRID being returned
- memtodr_ack_retry  out  1  tied 0
- outstanding  out  $clog2(NUM_DRID+1)  DRIDs currently allocated
- pf_drop_cnt  out  16  prefetches dropped (overflow or cancelled), wraps
- err_ack  out  1  sticky: ack for an unallocated DRID

Behaviour:
- Reset: all valids 0; outputs 0; queue empty; all DRIDs free; counters 0; err_ack 0. Reset asserted mid-transfer discards all in-flight state, with no flush.
- Handshake: transfer on valid & ~retry. Output payload holds stable while drtomem_req_valid & drtomem_req_retry.
- Demand buffer (1 entry):
  - dem_retry = dem_full & ~dem_pop (combinational).
  - Accepted at cycle N -> earliest drtomem_req_valid at N+2.
- Prefetch FIFO (head/tail pointers, per-entry valid bit):
  - Push when not full: write at tail.
  - Push when full, no pop: overwrite the oldest (head advances), pf_drop_cnt++.
  - Push and pop in the same cycle while full: no drop.
- Cancel: on demand accept, every valid queued entry with paddr[PADDR_W-1:6] equal to the demand's is invalidated; pf_drop_cnt += number cancelled. An incoming prefetch in the same cycle is compared too and dropped on match.
- Invalid head entries are popped silently, one per cycle, with no grant.
- Grant condition: output stage free (~drtomem_req_valid | ~drtomem_req_retry) AND at least one DRID free.
- Arbitration (one grant per cycle):
  - Demand wins unless starve_cnt == STARVE_MAX and the head prefetch is valid.
  - starve_cnt++ on each demand grant while a valid prefetch waits.
  - starve_cnt clears on a prefetch grant or when the queue is empty.
  - A prefetch grant drives cmd = PF_CMD.
- DRID pool (NUM_DRID-bit free bitmap):
  - Grant allocates the lowest free index.
  - Ack frees its DRID at the clock edge; the DRID is not reusable in the same cycle as the ack.
  - Ack with a DRID >= NUM_DRID or already free: err_ack <= 1, bitmap unchanged.
  - Pool empty: no grant. The demand buffer stays full -> dem_retry = 1.
- outstanding = popcount of allocated DRIDs, registered.

Decomposition:
- Shared package (scmem.vh):
  - I_drmem_sched_req_type {paddr, cmd, drid}
  - line-offset constant 6
  - PF_CMD encoding
- Sub-module dr_pf_queue: drop-oldest FIFO with per-entry valid and line-match cancel; outputs head entry, head_valid and a drop count per cycle.
- Top holds the demand buffer, arbiter, DRID bitmap and output register.

Test Plan:
- Single demand 0x1000, cmd 1, retry 0 -> cycle N+2: valid=1, paddr 0x1000, cmd 1, drid 0; outstanding=1. Ack drid 0 -> outstanding=0.
- 9 prefetches 0x40..0x240 with PF_DEPTH=8 and drtomem_req_retry=1 -> pf_drop_cnt=1. After retry drops, grants run 0x80..0x240 in order.
- Prefetch 0x1040 queued, then demand 0x1050 -> prefetch cancelled, pf_drop_cnt=1. Only 0x1050 reaches memory.
- Continuous demands plus one queued prefetch, STARVE_MAX=4 -> grant order D,D,D,D,P,D…
- NUM_DRID=2, no acks, 3 demands -> 2 grants (drid 0, 1), then dem_retry=1. Ack drid 1 -> third grant issued with drid 1 on a later cycle.
- Ack drid 5 while it is free -> err_ack=1 and stays 1 until reset. Reset asserted with drtomem_req_valid=1 -> next cycle valid=0, outstanding=0.

Source files
------------

// File: rtl/dr_memreq_sched_pkg.sv
// Shared types and constants for the directory-bank memory request scheduler.
package dr_memreq_sched_pkg;

    localparam int DEF_PADDR_W = 50;
    localparam int DEF_CMD_W   = 3;
    localparam int DEF_DRID_W  = 6;

    // Prefetch cancellation compares addresses at 64B line granularity.
    localparam int LINE_OFF = 6;

    // Command driven on drtomem_req for prefetch grants.
    localparam logic [DEF_CMD_W-1:0] PF_CMD_DEF = 3'd0;

    // One request as it leaves on the drtomem_req channel.
    typedef struct packed {
        logic [DEF_PADDR_W-1:0] paddr;
        logic [DEF_CMD_W-1:0]   cmd;
        logic [DEF_DRID_W-1:0]  drid;
    } I_drmem_sched_req_type;

    // Which source the arbiter picked this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DEM  = 2'd1,
        GNT_PF   = 2'd2
    } gnt_src_e;

endpackage

// File: rtl/dr_memreq_sched_pf_queue.sv
// Drop-oldest prefetch FIFO. Every entry carries a valid bit so a demand to
// the same line can cancel it in place; cancelled entries are skipped at the
// head one per cycle. drop_cnt reports how many prefetches died this cycle.
module dr_pf_queue
    import dr_memreq_sched_pkg::*;
#(
    parameter int PADDR_W  = 50,
    parameter int PF_DEPTH = 8,
    localparam int AW = $clog2(PF_DEPTH),
    localparam int CW = $clog2(PF_DEPTH + 2),
    localparam int LW = PADDR_W - LINE_OFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [PADDR_W-1:0] push_paddr,
    input  logic               grant,
    input  logic               cancel,
    input  logic [LW-1:0]      cancel_line,
    output logic               head_valid,
    output logic [PADDR_W-1:0] head_paddr,
    output logic               any_valid,
    output logic [CW-1:0]      drop_cnt
);

    logic [PADDR_W-1:0]  mem [PF_DEPTH];
    logic [PF_DEPTH-1:0] vld;
    logic [PF_DEPTH-1:0] vld_nxt;
    logic [PF_DEPTH-1:0] hit;
    logic [AW-1:0]       head;
    logic [AW-1:0]       tail;
    logic [AW:0]         count;
    logic                nonempty;
    logic                full;
    logic                pop;
    logic                in_hit;
    logic                do_push;
    logic                overwrite;

    // Head view, pop/push/overwrite decisions, cancel matches and drop count.
    always_comb begin
        nonempty   = (count != '0);
        full       = (count == (AW+1)'(PF_DEPTH));
        head_valid = nonempty & vld[head];
        head_paddr = mem[head];
        any_valid  = |vld;
        // Invalid heads leave without a grant; valid heads leave on grant.
        pop        = nonempty & (~vld[head] | grant);
        in_hit     = cancel & (push_paddr[PADDR_W-1:LINE_OFF] == cancel_line);
        do_push    = push & ~in_hit;
        overwrite  = do_push & full & ~pop;
        hit        = '0;
        for (int i = 0; i < PF_DEPTH; i++) begin
            hit[i] = cancel & vld[i] & (mem[i][PADDR_W-1:LINE_OFF] == cancel_line);
        end
        drop_cnt = '0;
        for (int i = 0; i < PF_DEPTH; i++) begin
            drop_cnt = drop_cnt + CW'(hit[i]);
        end
        drop_cnt = drop_cnt + CW'(in_hit);
        // A head that is cancelled this same cycle is already counted once.
        drop_cnt = drop_cnt + CW'(overwrite & ~hit[head]);
        vld_nxt  = vld & ~hit;
        if (pop) begin
            vld_nxt[head] = 1'b0;
        end
        // When full, tail == head, so a push reuses the slot just popped.
        if (do_push) begin
            vld_nxt[tail] = 1'b1;
        end
    end

    // Pointers, occupancy and valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            vld <= vld_nxt;
            if (do_push) begin
                tail <= tail + AW'(1);
            end
            if (pop | overwrite) begin
                head <= head + AW'(1);
            end
            count <= count + (AW+1)'(do_push & ~overwrite) - (AW+1)'(pop);
        end
    end

    // Address storage; contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_paddr;
        end
    end

endmodule

// File: rtl/dr_memreq_sched.sv
// Directory-bank scheduler owning the drtomem_req channel: a one-entry demand
// buffer and a prefetch queue are arbitrated into a registered output stage,
// each grant takes the lowest free DRID, and memtodr_ack returns DRIDs.
//
// Handshake: every channel transfers on a cycle where valid & ~retry. While
// drtomem_req_valid & drtomem_req_retry the request payload is held stable.
module dr_memreq_sched
    import dr_memreq_sched_pkg::*;
#(
    parameter int PADDR_W    = DEF_PADDR_W,
    parameter int CMD_W      = DEF_CMD_W,
    parameter int DRID_W     = DEF_DRID_W,
    parameter int NUM_DRID   = 16,
    parameter int PF_DEPTH   = 8,
    parameter logic [CMD_W-1:0] PF_CMD = CMD_W'(PF_CMD_DEF),
    parameter int STARVE_MAX = 4,
    localparam int OW = $clog2(NUM_DRID + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dem_valid,
    output logic               dem_retry,
    input  logic [PADDR_W-1:0] dem_paddr,
    input  logic [CMD_W-1:0]   dem_cmd,
    input  logic               pf_valid,
    output logic               pf_retry,
    input  logic [PADDR_W-1:0] pf_paddr,
    output logic               drtomem_req_valid,
    input  logic               drtomem_req_retry,
    output logic [PADDR_W-1:0] drtomem_req_paddr,
    output logic [CMD_W-1:0]   drtomem_req_cmd,
    output logic [DRID_W-1:0]  drtomem_req_drid,
    input  logic               memtodr_ack_valid,
    input  logic [DRID_W-1:0]  memtodr_ack_drid,
    output logic               memtodr_ack_retry,
    output logic [OW-1:0]      outstanding,
    output logic [15:0]        pf_drop_cnt,
    output logic               err_ack
);

    localparam int QCW = $clog2(PF_DEPTH + 2);
    localparam int SW  = $clog2(STARVE_MAX + 1);

    logic               dem_full;
    logic [PADDR_W-1:0] dem_buf_paddr;
    logic [CMD_W-1:0]   dem_buf_cmd;
    logic               dem_acc;
    logic               dem_pop;
    logic [NUM_DRID-1:0] free_map;
    logic [NUM_DRID-1:0] alloc_oh;
    logic [NUM_DRID-1:0] ack_oh;
    logic [DRID_W-1:0]  alloc_idx;
    logic               ack_ok;
    logic               ack_bad;
    logic               can_grant;
    logic               pf_turn;
    logic               granted;
    gnt_src_e           gnt_src;
    logic [SW-1:0]      starve_cnt;
    logic               q_head_valid;
    logic               q_any_valid;
    logic [PADDR_W-1:0] q_head_paddr;
    logic [QCW-1:0]     q_drop;

    assign pf_retry          = 1'b0;
    assign memtodr_ack_retry = 1'b0;

    dr_pf_queue #(
        .PADDR_W  (PADDR_W),
        .PF_DEPTH (PF_DEPTH)
    ) u_pf_queue (
        .clk         (clk),
        .reset       (reset),
        .push        (pf_valid),
        .push_paddr  (pf_paddr),
        .grant       (gnt_src == GNT_PF),
        .cancel      (dem_acc),
        .cancel_line (dem_paddr[PADDR_W-1:LINE_OFF]),
        .head_valid  (q_head_valid),
        .head_paddr  (q_head_paddr),
        .any_valid   (q_any_valid),
        .drop_cnt    (q_drop)
    );

    // Arbitration: demand first unless a waiting prefetch has been starved.
    always_comb begin
        can_grant = (~drtomem_req_valid | ~drtomem_req_retry) & (|free_map);
        pf_turn   = q_head_valid & (starve_cnt == SW'(STARVE_MAX));
        gnt_src   = GNT_NONE;
        if (can_grant) begin
            if (dem_full & ~pf_turn) begin
                gnt_src = GNT_DEM;
            end else if (q_head_valid) begin
                gnt_src = GNT_PF;
            end
        end
        granted   = (gnt_src != GNT_NONE);
        dem_pop   = (gnt_src == GNT_DEM);
        dem_retry = dem_full & ~dem_pop;
        dem_acc   = dem_valid & ~dem_retry;
    end

    // Lowest free DRID, and validation of the returning ack against the pool.
    always_comb begin
        alloc_idx = '0;
        alloc_oh  = '0;
        for (int i = NUM_DRID - 1; i >= 0; i--) begin
            if (free_map[i]) begin
                alloc_idx = DRID_W'(i);
                alloc_oh  = NUM_DRID'(1) << i;
            end
        end
        ack_oh  = '0;
        ack_bad = memtodr_ack_valid;
        if (memtodr_ack_valid) begin
            for (int i = 0; i < NUM_DRID; i++) begin
                if ((memtodr_ack_drid == DRID_W'(i)) && !free_map[i]) begin
                    ack_oh[i] = 1'b1;
                    ack_bad   = 1'b0;
                end
            end
        end
        ack_ok = |ack_oh;
    end

    // Registered output stage: load on grant, clear once the request transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            drtomem_req_valid <= 1'b0;
            drtomem_req_paddr <= '0;
            drtomem_req_cmd   <= '0;
            drtomem_req_drid  <= '0;
        end else if (granted) begin
            drtomem_req_valid <= 1'b1;
            drtomem_req_paddr <= dem_pop ? dem_buf_paddr : q_head_paddr;
            drtomem_req_cmd   <= dem_pop ? dem_buf_cmd : PF_CMD;
            drtomem_req_drid  <= alloc_idx;
        end else if (!drtomem_req_retry) begin
            drtomem_req_valid <= 1'b0;
        end
    end

    // One-entry demand buffer; a new demand may enter in the cycle it drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            dem_full      <= 1'b0;
            dem_buf_paddr <= '0;
            dem_buf_cmd   <= '0;
        end else if (dem_acc) begin
            dem_full      <= 1'b1;
            dem_buf_paddr <= dem_paddr;
            dem_buf_cmd   <= dem_cmd;
        end else if (dem_pop) begin
            dem_full <= 1'b0;
        end
    end

    // DRID pool: an acked DRID only becomes allocatable from the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_map    <= '1;
            outstanding <= '0;
            err_ack     <= 1'b0;
        end else begin
            free_map    <= (free_map & ~(granted ? alloc_oh : '0)) | ack_oh;
            outstanding <= outstanding + OW'(granted) - OW'(ack_ok);
            err_ack     <= err_ack | ack_bad;
        end
    end

    // Starvation counter and the wrapping prefetch drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt  <= '0;
            pf_drop_cnt <= '0;
        end else begin
            pf_drop_cnt <= pf_drop_cnt + 16'(q_drop);
            if ((gnt_src == GNT_PF) || !q_any_valid) begin
                starve_cnt <= '0;
            end else if (dem_pop && (starve_cnt != SW'(STARVE_MAX))) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dr_memreq_sched.sv
// Directed bench for dr_memreq_sched: a default instance and a two-DRID
// instance, with per-instance expected-request queues checked at transfer.
module tb_dr_memreq_sched;

    localparam int PADDR_W = 50;
    localparam int CMD_W   = 3;
    localparam int DRID_W  = 6;
    localparam int RW      = DRID_W + CMD_W + PADDR_W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- default instance ----------------
    logic               dem_valid = 0, dem_retry, pf_valid = 0, pf_retry;
    logic [PADDR_W-1:0] dem_paddr = '0, pf_paddr = '0;
    logic [CMD_W-1:0]   dem_cmd = '0;
    logic               req_valid, req_retry = 0;
    logic [PADDR_W-1:0] req_paddr;
    logic [CMD_W-1:0]   req_cmd;
    logic [DRID_W-1:0]  req_drid;
    logic               ack_valid = 0, ack_retry;
    logic [DRID_W-1:0]  ack_drid = '0;
    logic [4:0]         outstanding;
    logic [15:0]        pf_drop_cnt;
    logic               err_ack;

    dr_memreq_sched u_dut (
        .clk(clk), .reset(reset),
        .dem_valid(dem_valid), .dem_retry(dem_retry), .dem_paddr(dem_paddr), .dem_cmd(dem_cmd),
        .pf_valid(pf_valid), .pf_retry(pf_retry), .pf_paddr(pf_paddr),
        .drtomem_req_valid(req_valid), .drtomem_req_retry(req_retry),
        .drtomem_req_paddr(req_paddr), .drtomem_req_cmd(req_cmd), .drtomem_req_drid(req_drid),
        .memtodr_ack_valid(ack_valid), .memtodr_ack_drid(ack_drid), .memtodr_ack_retry(ack_retry),
        .outstanding(outstanding), .pf_drop_cnt(pf_drop_cnt), .err_ack(err_ack)
    );

    // ---------------- two-DRID instance ----------------
    logic               d2_dem_valid = 0, d2_dem_retry, d2_pf_retry;
    logic [PADDR_W-1:0] d2_dem_paddr = '0;
    logic [PADDR_W-1:0] d2_pf_paddr = '0;
    logic [CMD_W-1:0]   d2_dem_cmd = '0;
    logic               d2_pf_valid = 0;
    logic               d2_req_valid, d2_req_retry = 0;
    logic [PADDR_W-1:0] d2_req_paddr;
    logic [CMD_W-1:0]   d2_req_cmd;
    logic [DRID_W-1:0]  d2_req_drid;
    logic               d2_ack_valid = 0, d2_ack_retry;
    logic [DRID_W-1:0]  d2_ack_drid = '0;
    logic [1:0]         d2_outstanding;
    logic [15:0]        d2_pf_drop_cnt;
    logic               d2_err_ack;

    dr_memreq_sched #(.NUM_DRID(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .dem_valid(d2_dem_valid), .dem_retry(d2_dem_retry), .dem_paddr(d2_dem_paddr), .dem_cmd(d2_dem_cmd),
        .pf_valid(d2_pf_valid), .pf_retry(d2_pf_retry), .pf_paddr(d2_pf_paddr),
        .drtomem_req_valid(d2_req_valid), .drtomem_req_retry(d2_req_retry),
        .drtomem_req_paddr(d2_req_paddr), .drtomem_req_cmd(d2_req_cmd), .drtomem_req_drid(d2_req_drid),
        .memtodr_ack_valid(d2_ack_valid), .memtodr_ack_drid(d2_ack_drid), .memtodr_ack_retry(d2_ack_retry),
        .outstanding(d2_outstanding), .pf_drop_cnt(d2_pf_drop_cnt), .err_ack(d2_err_ack)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp2_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] req_word(input int drid, input int cmd, input logic [PADDR_W-1:0] paddr);
        return {DRID_W'(drid), CMD_W'(cmd), paddr};
    endfunction

    // Each transfer must match the head of the expected queue.
    always @(negedge clk) begin
        logic [RW-1:0] w;
        if (!reset && req_valid && !req_retry) begin
            check("req_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("req_word", 64'({req_drid, req_cmd, req_paddr}), 64'(w));
            end
        end
        if (!reset && d2_req_valid && !d2_req_retry) begin
            check("d2_req_expected", 64'(exp2_q.size() != 0), 64'd1);
            if (exp2_q.size() != 0) begin
                w = exp2_q.pop_front();
                check("d2_req_word", 64'({d2_req_drid, d2_req_cmd, d2_req_paddr}), 64'(w));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dem_send(input logic [PADDR_W-1:0] a, input logic [CMD_W-1:0] c);
        int waited = 0;
        dem_valid = 1'b1;
        dem_paddr = a;
        dem_cmd   = c;
        @(negedge clk);
        while (dem_retry && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) check("dem_accept_timeout", 64'(dem_retry), 64'd0);
        @(posedge clk);
        #1;
        dem_valid = 1'b0;
    endtask

    task automatic ack(input int drid);
        ack_valid = 1'b1;
        ack_drid  = DRID_W'(drid);
        tick();
        ack_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        tick(2);
        reset = 1'b0;
        check("rst_valid", 64'(req_valid), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_drop", 64'(pf_drop_cnt), 64'd0);
        check("rst_err", 64'(err_ack), 64'd0);
        check("rst_dem_retry", 64'(dem_retry), 64'd0);
        check("pf_retry_tied", 64'(pf_retry), 64'd0);
        check("ack_retry_tied", 64'(ack_retry), 64'd0);

        // Single demand: visible two cycles after acceptance, drid 0.
        exp_q.push_back(req_word(0, 1, 50'h1000));
        dem_send(50'h1000, 3'd1);
        check("t1_valid_n1", 64'(req_valid), 64'd0);
        tick();
        check("t1_valid_n2", 64'(req_valid), 64'd1);
        check("t1_paddr", 64'(req_paddr), 64'h1000);
        check("t1_cmd", 64'(req_cmd), 64'd1);
        check("t1_drid", 64'(req_drid), 64'd0);
        check("t1_outstanding", 64'(outstanding), 64'd1);
        tick();
        check("t1_valid_clear", 64'(req_valid), 64'd0);
        ack(0);
        check("t1_outstanding_ack", 64'(outstanding), 64'd0);

        // Prefetch overflow behind a stalled demand: oldest (0x40) dropped.
        req_retry = 1'b1;
        exp_q.push_back(req_word(0, 2, 50'h2000));
        dem_send(50'h2000, 3'd2);
        tick();
        check("t2_stall_valid", 64'(req_valid), 64'd1);
        for (int i = 1; i <= 9; i++) begin
            pf_valid = 1'b1;
            pf_paddr = PADDR_W'(i * 64);
            tick();
        end
        pf_valid = 1'b0;
        check("t2_drop", 64'(pf_drop_cnt), 64'd1);
        check("t2_hold_paddr", 64'(req_paddr), 64'h2000);
        check("t2_hold_valid", 64'(req_valid), 64'd1);
        for (int i = 2; i <= 9; i++) exp_q.push_back(req_word(i - 1, 0, PADDR_W'(i * 64)));
        req_retry = 1'b0;
        tick(12);
        check("t2_q_drained", 64'(exp_q.size()), 64'd0);
        check("t2_outstanding", 64'(outstanding), 64'd9);
        for (int i = 0; i <= 8; i++) ack(i);
        check("t2_outstanding_acked", 64'(outstanding), 64'd0);
        check("t2_no_err", 64'(err_ack), 64'd0);

        // Line-match cancel: queued 0x1040 and incoming 0x1060 die with 0x1050.
        req_retry = 1'b1;
        exp_q.push_back(req_word(0, 1, 50'h3000));
        exp_q.push_back(req_word(1, 4, 50'h1050));
        exp_q.push_back(req_word(2, 0, 50'h1080));
        dem_send(50'h3000, 3'd1);
        tick();
        pf_valid = 1'b1; pf_paddr = 50'h1040; tick();
        pf_valid = 1'b1; pf_paddr = 50'h1080; tick();
        pf_valid = 1'b1; pf_paddr = 50'h1060;
        dem_send(50'h1050, 3'd4);
        pf_valid = 1'b0;
        tick(2);
        check("t3_drop", 64'(pf_drop_cnt), 64'd3);
        check("t3_dem_retry_full", 64'(dem_retry), 64'd1);
        req_retry = 1'b0;
        tick(6);
        check("t3_q_drained", 64'(exp_q.size()), 64'd0);
        check("t3_outstanding", 64'(outstanding), 64'd3);

        // Starvation: D,D,D,D,P,D,D with STARVE_MAX=4.
        exp_q.push_back(req_word(3, 3, 50'h100));
        exp_q.push_back(req_word(4, 3, 50'h140));
        exp_q.push_back(req_word(5, 3, 50'h180));
        exp_q.push_back(req_word(6, 3, 50'h1c0));
        exp_q.push_back(req_word(7, 0, 50'h8000));
        exp_q.push_back(req_word(8, 3, 50'h200));
        exp_q.push_back(req_word(9, 3, 50'h240));
        pf_valid = 1'b1; pf_paddr = 50'h8000;
        dem_send(50'h100, 3'd3);
        pf_valid = 1'b0;
        dem_send(50'h140, 3'd3);
        dem_send(50'h180, 3'd3);
        dem_send(50'h1c0, 3'd3);
        dem_send(50'h200, 3'd3);
        dem_send(50'h240, 3'd3);
        tick(6);
        check("t4_q_drained", 64'(exp_q.size()), 64'd0);
        check("t4_outstanding", 64'(outstanding), 64'd10);
        check("t4_drop_same", 64'(pf_drop_cnt), 64'd3);

        // Bad acks: free DRID 12, then out-of-range 40; pool untouched, sticky error.
        ack(12);
        check("t5_err", 64'(err_ack), 64'd1);
        check("t5_outstanding", 64'(outstanding), 64'd10);
        tick(3);
        check("t5_err_sticky", 64'(err_ack), 64'd1);
        ack(40);
        check("t5_outstanding_range", 64'(outstanding), 64'd10);

        // Two-DRID pool exhaustion on the second instance.
        exp2_q.push_back(req_word(0, 1, 50'ha000));
        exp2_q.push_back(req_word(1, 1, 50'ha040));
        d2_dem_valid = 1'b1; d2_dem_cmd = 3'd1;
        d2_dem_paddr = 50'ha000; tick();
        d2_dem_paddr = 50'ha040; tick();
        d2_dem_paddr = 50'ha080; tick();
        d2_dem_valid = 1'b0;
        tick(2);
        check("t6_dem_retry", 64'(d2_dem_retry), 64'd1);
        check("t6_outstanding", 64'(d2_outstanding), 64'd2);
        check("t6_no_grant", 64'(d2_req_valid), 64'd0);
        check("t6_q_two", 64'(exp2_q.size()), 64'd0);
        exp2_q.push_back(req_word(1, 1, 50'ha080));
        d2_ack_valid = 1'b1; d2_ack_drid = 6'd1; tick();
        d2_ack_valid = 1'b0;
        check("t6_no_same_cycle_reuse", 64'(d2_req_valid), 64'd0);
        tick();
        check("t6_third_valid", 64'(d2_req_valid), 64'd1);
        check("t6_third_drid", 64'(d2_req_drid), 64'd1);
        check("t6_third_paddr", 64'(d2_req_paddr), 64'ha080);
        tick(2);
        check("t6_q_drained", 64'(exp2_q.size()), 64'd0);
        d2_ack_valid = 1'b1; d2_ack_drid = 6'd3; tick();
        d2_ack_valid = 1'b0;
        check("t6_err_range", 64'(d2_err_ack), 64'd1);
        check("t6_outstanding_kept", 64'(d2_outstanding), 64'd2);

        // Reset while a request is stalled on the output.
        req_retry = 1'b1;
        dem_send(50'h4000, 3'd1);
        tick();
        check("t7_pre_valid", 64'(req_valid), 64'd1);
        reset = 1'b1;
        tick();
        check("t7_valid", 64'(req_valid), 64'd0);
        check("t7_outstanding", 64'(outstanding), 64'd0);
        check("t7_err", 64'(err_ack), 64'd0);
        check("t7_drop", 64'(pf_drop_cnt), 64'd0);
        check("t7_d2_err", 64'(d2_err_ack), 64'd0);
        check("t7_d2_outstanding", 64'(d2_outstanding), 64'd0);
        reset = 1'b0;
        req_retry = 1'b0;
        tick(3);
        check("t7_no_replay", 64'(req_valid), 64'd0);
        check("t7_q_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
